datamemory_arbiter: RTL and testbench



---
 rtl/datamemory_arbiter.sv | 143 ++++++++++++++
 tb/tb_datamemory_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/datamemory_arbiter.sv
// Purpose : shares one single-ported datamemory between port A (CPU) and port B (loader), round-robin on ties.
// Latency : req high in IDLE -> ACCESS next cycle -> ack (with read data) the cycle after; alternating ports chain RESP->ACCESS.
// Backpres: none explicit; a requester holds req/we/addr/wdata until its ack, the losing port simply waits.
//
// Ports:
//   clk, resetN                  clock, synchronous active-low reset
//   reqX/weX/addrX/wdataX        request, write flag, word address, write data per port
//   ackX/rdataX                  one-cycle completion pulse, read data (0 unless ack of a read)
//   grantX/busy                  port owns the memory (ACCESS/RESP), FSM not idle
//   mem*                         datamemory control/data; memDout is the registered read result
module datamemory_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  reqA,
    input  logic                  weA,
    input  logic [ADDR_WIDTH-1:0] addrA,
    input  logic [DATA_WIDTH-1:0] wdataA,
    input  logic                  reqB,
    input  logic                  weB,
    input  logic [ADDR_WIDTH-1:0] addrB,
    input  logic [DATA_WIDTH-1:0] wdataB,
    output logic                  ackA,
    output logic [DATA_WIDTH-1:0] rdataA,
    output logic                  grantA,
    output logic                  ackB,
    output logic [DATA_WIDTH-1:0] rdataB,
    output logic                  grantB,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] memReadAddr,
    output logic [ADDR_WIDTH-1:0] memWriteAddr,
    output logic                  memReadEn,
    output logic                  memWriteEn,
    output logic [DATA_WIDTH-1:0] memDin,
    input  logic [DATA_WIDTH-1:0] memDout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic grant_en;
    logic grant_port;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant_en     = 1'b0;
        grant_port   = PORT_A;

        case (state_q)
            S_IDLE: begin
                if (reqA || reqB) begin
                    grant_en = 1'b1;
                    if (reqA && reqB) begin
                        grant_port = ~last_grant_q;
                    end else begin
                        grant_port = reqB ? PORT_B : PORT_A;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                // The owner's req is still high during its ack cycle, so only the
                // other port may be granted here; the owner re-enters via IDLE.
                if ((owner_q == PORT_A) ? reqB : reqA) begin
                    grant_en   = 1'b1;
                    grant_port = ~owner_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant_en) begin
            state_d      = S_ACCESS;
            owner_d      = grant_port;
            last_grant_d = grant_port;
            we_d         = (grant_port == PORT_B) ? weB    : weA;
            addr_d       = (grant_port == PORT_B) ? addrB  : addrA;
            wdata_d      = (grant_port == PORT_B) ? wdataB : wdataA;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            owner_q      <= PORT_A;
            last_grant_q <= PORT_B;  // A wins the first tie after reset
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Enables decode from registered state only, so a reset asserted during
    // ACCESS still lets that cycle's write commit at the edge.
    assign memWriteEn   = (state_q == S_ACCESS) &&  we_q;
    assign memReadEn    = (state_q == S_ACCESS) && !we_q;
    assign memReadAddr  = addr_q;
    assign memWriteAddr = addr_q;
    assign memDin       = wdata_q;

    assign busy   = (state_q != S_IDLE);
    assign grantA = busy && (owner_q == PORT_A);
    assign grantB = busy && (owner_q == PORT_B);

    assign ackA   = (state_q == S_RESP) && (owner_q == PORT_A);
    assign ackB   = (state_q == S_RESP) && (owner_q == PORT_B);
    assign rdataA = (ackA && !we_q) ? memDout : '0;
    assign rdataB = (ackB && !we_q) ? memDout : '0;

endmodule

// File: tb/tb_datamemory_arbiter.sv
// Purpose : directed bench for datamemory_arbiter with a behavioural registered-read memory.
// Latency : each step advances one clock; outputs are sampled 1 time unit after the rising edge.
// Backpres: none; requesters follow the hold-until-ack protocol.
module tb_datamemory_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetN;
    logic          reqA, weA, reqB, weB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] wdataA, wdataB;
    logic          ackA, ackB, grantA, grantB, busy;
    logic [DW-1:0] rdataA, rdataB;
    logic [AW-1:0] memReadAddr, memWriteAddr;
    logic          memReadEn, memWriteEn;
    logic [DW-1:0] memDin, memDout;

    // Preload port into the memory model, used only while the arbiter is idle.
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_dat;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    datamemory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .resetN(resetN),
        .reqA(reqA), .weA(weA), .addrA(addrA), .wdataA(wdataA),
        .reqB(reqB), .weB(weB), .addrB(addrB), .wdataB(wdataB),
        .ackA(ackA), .rdataA(rdataA), .grantA(grantA),
        .ackB(ackB), .rdataB(rdataB), .grantB(grantB),
        .busy(busy),
        .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
        .memReadEn(memReadEn), .memWriteEn(memWriteEn),
        .memDin(memDin), .memDout(memDout)
    );

    always @(posedge clk) begin
        if (memWriteEn) mem[memWriteAddr] <= memDin;
        else if (pre_we) mem[pre_addr] <= pre_dat;
        if (memReadEn) memDout <= mem[memReadAddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        step();
        pre_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; reqA = 1'b1; reqB = 1'b1; weA = 1'b0; weB = 1'b0;
        addrA = '0; addrB = '0; wdataA = '0; wdataB = '0;
        pre_we = 1'b0; pre_addr = '0; pre_dat = '0;

        // ---------------- reset held with both requests high
        step(); step();
        chk("rst_busy",   busy, 0);
        chk("rst_grant",  {grantA, grantB}, 0);
        chk("rst_ack",    {ackA, ackB}, 0);
        chk("rst_en",     {memReadEn, memWriteEn}, 0);
        chk("rst_rdata",  rdataA | rdataB, 0);
        chk("rst_maddr",  memReadAddr, 0);
        chk("rst_din",    memDin, 0);
        resetN = 1'b1;
        chk("rel_idle",   busy, 0);
        step();
        chk("rel_grantA", {grantA, grantB}, 2'b10);
        chk("rel_rden",   memReadEn, 1);
        step();
        chk("rel_ackA",   ackA, 1);
        // reset during RESP: that ack was the last output
        resetN = 1'b0;
        step();
        chk("rresp_ack",  {ackA, ackB}, 0);
        chk("rresp_busy", busy, 0);
        chk("rresp_grnt", {grantA, grantB}, 0);
        reqA = 1'b0; reqB = 1'b0;
        step();
        resetN = 1'b1;

        // ---------------- A writes 5 to addr 0, then reads it back
        reqA = 1'b1; weA = 1'b1; addrA = 14'd0; wdataA = 32'd5;
        step();
        chk("wr_we",      memWriteEn, 1);
        chk("wr_re",      memReadEn, 0);
        chk("wr_din",     memDin, 32'd5);
        chk("wr_waddr",   memWriteAddr, 0);
        chk("wr_noack",   ackA, 0);
        chk("wr_rdB_c1",  rdataB, 0);
        step();
        chk("wr_ackA",    ackA, 1);
        chk("wr_we_c2",   memWriteEn, 0);
        chk("wr_rdataA",  rdataA, 0);
        chk("wr_rdB_c2",  rdataB, 0);
        step();
        weA = 1'b0;           // same port re-request goes through IDLE
        chk("b2b_idle",   busy, 0);
        step();
        chk("rd_re",      memReadEn, 1);
        chk("rd_we",      memWriteEn, 0);
        step();
        chk("rd_ackA",    ackA, 1);
        chk("rd_rdataA",  rdataA, 32'd5);
        chk("rd_rdB",     rdataB, 0);
        step();
        reqA = 1'b0;

        // ---------------- simultaneous reads after reset
        preload(14'd3, 32'h11);
        preload(14'd7, 32'h22);
        preload(14'd21, 32'h55);
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        reqA = 1'b1; weA = 1'b0; addrA = 14'd3;
        reqB = 1'b1; weB = 1'b0; addrB = 14'd7;
        step();
        chk("sim_grantA", {grantA, grantB}, 2'b10);
        step();
        chk("sim_ackA",   {ackA, ackB}, 2'b10);
        chk("sim_rdA",    rdataA, 32'h11);
        step();
        reqA = 1'b0;
        chk("sim_nobusy", busy, 1);
        chk("sim_grantB", {grantA, grantB}, 2'b01);
        step();
        chk("sim_ackB",   {ackA, ackB}, 2'b01);
        chk("sim_rdB",    rdataB, 32'h22);
        chk("sim_rdA0",   rdataA, 0);
        step();
        reqB = 1'b0;
        chk("sim_idle",   busy, 0);

        // ---------------- continuous contention, A writes and B reads
        reqA = 1'b1; weA = 1'b1; addrA = 14'd20; wdataA = 32'h77;
        reqB = 1'b1; weB = 1'b0; addrB = 14'd21;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk($sformatf("cont_ackA_%0d", c), ackA, ((c % 4) == 2) ? 1 : 0);
            chk($sformatf("cont_ackB_%0d", c), ackB, ((c % 4) == 0) ? 1 : 0);
            chk($sformatf("cont_en_%0d", c), memReadEn & memWriteEn, 0);
            if ((c % 4) == 0) chk($sformatf("cont_rdB_%0d", c), rdataB, 32'h55);
        end
        step();
        reqB = 1'b0;
        chk("cont_accA",  {grantA, memWriteEn}, 2'b11);
        step();
        chk("cont_lastA", ackA, 1);
        step();
        reqA = 1'b0;

        // ---------------- top address
        reqB = 1'b1; weB = 1'b1; addrB = 14'h3FFF; wdataB = 32'hDEADBEEF;
        step();
        chk("top_we",     memWriteEn, 1);
        chk("top_waddr",  memWriteAddr, 32'd16383);
        chk("top_din",    memDin, 32'hDEADBEEF);
        step();
        chk("top_ackB",   ackB, 1);
        step();
        reqB = 1'b0; weB = 1'b0;
        reqA = 1'b1; weA = 1'b0; addrA = 14'h3FFF;
        step();
        chk("top_re",     memReadEn, 1);
        chk("top_raddr",  memReadAddr, 32'd16383);
        step();
        chk("top_ackA",   ackA, 1);
        chk("top_rdA",    rdataA, 32'hDEADBEEF);
        step();
        reqA = 1'b0;

        // ---------------- reset during ACCESS of a write
        reqA = 1'b1; weA = 1'b1; addrA = 14'd9; wdataA = 32'hAA;
        step();
        chk("rmw_we",     memWriteEn, 1);
        resetN = 1'b0;
        chk("rmw_we_rst", memWriteEn, 1);
        step();
        chk("rmw_noack",  ackA, 0);
        chk("rmw_busy",   busy, 0);
        chk("rmw_grant",  {grantA, grantB}, 0);
        chk("rmw_en",     {memReadEn, memWriteEn}, 0);
        resetN = 1'b1;
        reqA = 1'b1; weA = 1'b0; addrA = 14'd9;
        step();
        step();
        chk("rmw_ackA",   ackA, 1);
        chk("rmw_rdA",    rdataA, 32'hAA);
        step();
        reqA = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
